// File: rtl/mem_access_sched.sv
// Memory-port sequencer for the multicycle CPU: arbitrates fetch, load/store and
// exception-vector reads. Optional fetch-starvation guard under MEM_SCHED_FAIRNESS_EN.
module mem_access_sched #(
  parameter int MEM_LATENCY = 2,
  parameter int FAIR_LIMIT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic       data_we,
  input  logic [1:0] data_src,
  input  logic       exc_req,
  input  logic [1:0] exc_code,
  output logic [2:0] MemoryAdress,
  output logic       mem_wr,
  output logic       mdr_load,
  output logic       fetch_ack,
  output logic       data_ack,
  output logic       exc_ack,
  output logic       busy
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_access_sched: MEM_LATENCY must be in 1..15");
  end
  if (FAIR_LIMIT < 1) begin : g_bad_fair_limit
    $error("mem_access_sched: FAIR_LIMIT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DATA, GNT_EXC} grant_t;

  state_t     state_q;
  grant_t     grant_q, grant_d;
  logic [3:0] cnt_q;
  logic       store_q;
  logic [2:0] sel_q, sel_d;
  logic       mem_wr_q, mdr_load_q, fetch_ack_q, data_ack_q, exc_ack_q, busy_q;
  logic       fetch_first_d;

`ifdef MEM_SCHED_FAIRNESS_EN
  localparam int FAIR_W = $clog2(FAIR_LIMIT + 2);
  logic [FAIR_W-1:0] fair_cnt_q;

  assign fetch_first_d = fetch_req && (fair_cnt_q == FAIR_W'(FAIR_LIMIT));

  // Counts data/exc grants that made a pending fetch wait; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      fair_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_d == GNT_FETCH) begin
        fair_cnt_q <= '0;
      end else if ((grant_d == GNT_DATA || grant_d == GNT_EXC) && fetch_req &&
                   (fair_cnt_q != FAIR_W'(FAIR_LIMIT))) begin
        fair_cnt_q <= fair_cnt_q + 1'b1;
      end
    end
  end
`else
  assign fetch_first_d = 1'b0;
`endif

  always_comb begin
    grant_d = GNT_NONE;
    sel_d   = 3'b000;
    if (exc_req) begin
      grant_d = GNT_EXC;
      unique case (exc_code)
        2'b01:   sel_d = 3'b101;
        2'b10:   sel_d = 3'b110;
        default: sel_d = 3'b100;
      endcase
    end else if (fetch_first_d) begin
      grant_d = GNT_FETCH;
    end else if (data_req) begin
      grant_d = GNT_DATA;
      unique case (data_src)
        2'b00:   sel_d = 3'b001;
        2'b01:   sel_d = 3'b010;
        2'b10:   sel_d = 3'b011;
        default: sel_d = 3'b111;
      endcase
    end else if (fetch_req) begin
      grant_d = GNT_FETCH;
    end
  end

  // Select, write strobe and request kind are captured once at grant and held to the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      cnt_q       <= 4'd0;
      store_q     <= 1'b0;
      sel_q       <= 3'b000;
      mem_wr_q    <= 1'b0;
      mdr_load_q  <= 1'b0;
      fetch_ack_q <= 1'b0;
      data_ack_q  <= 1'b0;
      exc_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          mem_wr_q    <= 1'b0;
          mdr_load_q  <= 1'b0;
          fetch_ack_q <= 1'b0;
          data_ack_q  <= 1'b0;
          exc_ack_q   <= 1'b0;
          if (grant_d != GNT_NONE) begin
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            store_q  <= (grant_d == GNT_DATA) && data_we;
            mem_wr_q <= (grant_d == GNT_DATA) && data_we;
            cnt_q    <= 4'(MEM_LATENCY);
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            mem_wr_q    <= 1'b0;
            mdr_load_q  <= !store_q;
            fetch_ack_q <= (grant_q == GNT_FETCH);
            data_ack_q  <= (grant_q == GNT_DATA);
            exc_ack_q   <= (grant_q == GNT_EXC);
            state_q     <= DONE;
          end
        end
        DONE: begin
          mdr_load_q  <= 1'b0;
          fetch_ack_q <= 1'b0;
          data_ack_q  <= 1'b0;
          exc_ack_q   <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MemoryAdress = sel_q;
  assign mem_wr       = mem_wr_q;
  assign mdr_load     = mdr_load_q;
  assign fetch_ack    = fetch_ack_q;
  assign data_ack     = data_ack_q;
  assign exc_ack      = exc_ack_q;
  assign busy         = busy_q;

endmodule

// File: doc/mem_access_sched.md
Name: mem_access_sched

Overview:
- Sequencer/arbiter for the shared memory port of the multicycle CPU.
- Three requesters share the memory: instruction fetch, load/store, and exception vector read.
- Grants one requester at a time and drives the 3-bit memory-address mux select and the memory write strobe.
- Waits out the memory latency, then returns a one-cycle ack and an MDR load strobe.

Parameters:
- MEM_LATENCY, 2, cycles from the address being presented to read data valid or write committed (legal range 1..15).
- FAIR_LIMIT, 4, consecutive non-fetch grants tolerated while fetch is pending (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  instruction fetch request; address source is pc.
- data_req  in  1  load/store request.
- data_we  in  1  1 = store, 0 = load; valid with data_req.
- data_src  in  2  data address source: 00 ulaResult, 01 ext16_32, 10 ulaOut, 11 ext25_32.
- exc_req  in  1  exception vector read request.
- exc_code  in  2  vector: 00 → 253, 01 → 254, 10 → 255, 11 reserved (treated as 00).
- MemoryAdress  out  3  address mux select: 000 pc, 001 ulaResult, 010 ext16_32, 011 ulaOut, 100 253, 101 254, 110 255, 111 ext25_32.
- mem_wr  out  1  memory write enable.
- mdr_load  out  1  one-cycle strobe to load the memory data register (reads only).
- fetch_ack  out  1  one-cycle completion pulse for fetch.
- data_ack  out  1  one-cycle completion pulse for load/store.
- exc_ack  out  1  one-cycle completion pulse for vector read.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE, MemoryAdress 000, mem_wr 0, mdr_load 0, all acks 0, busy 0, wait counter 0, fairness counter 0.
- Reset mid-access aborts the access immediately; no ack is issued for it.
- Registered outputs: all outputs come from registers, with no combinational path from any req to any output.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If any req is high, grant by fixed priority exc > data > fetch.
  - Latch the select (from exc_code, data_src, or 000) into MemoryAdress.
  - mem_wr is set to data_we only when data is granted; otherwise 0.
  - Load counter = MEM_LATENCY, busy = 1, go to WAIT.
  - With no req, MemoryAdress holds its last value, mem_wr stays 0, state stays IDLE.
- WAIT:
  - MemoryAdress and mem_wr held stable.
  - Counter decrements each cycle; when counter == 1, go to DONE.
  - mem_wr is high for exactly MEM_LATENCY cycles on a store.
- DONE (one cycle):
  - mem_wr = 0.
  - The ack for the granted requester is pulsed.
  - mdr_load = 1 for fetch, load, or vector read; 0 for store.
  - MemoryAdress still held; next state IDLE, busy = 0 in IDLE.
- Latency: a request sampled in IDLE at edge N gets its ack high in cycle N+MEM_LATENCY+1.
  - Back-to-back accesses run every MEM_LATENCY+2 cycles.
- Handshake:
  - A req is level-sensitive and must be held until its ack.
  - A requester drops req in the ack cycle; if still high in IDLE, it is re-granted as a new access.
  - data_we, data_src and exc_code are sampled only at grant; later changes are ignored.
- Simultaneous events:
  - A req rising while busy waits; accesses are never preempted.
  - Several reqs pending at IDLE resolve by priority only.
- Reserved exc_code 11 selects 100 (vector 253).

Optional Feature:
- Macro: MEM_SCHED_FAIRNESS_EN.
- Defined:
  - A counter counts consecutive data/exc grants while fetch_req is high at the grant; it clears on any fetch grant and on reset.
  - When counter == FAIR_LIMIT and fetch_req is high, fetch beats data at the next grant; exc still beats fetch.
- Not defined: strict exc > data > fetch priority; no counter logic is present.

Test Plan:
- Reset, then fetch_req=1 held: MemoryAdress=000 from cycle 1, fetch_ack=1 and mdr_load=1 in cycle 3 (MEM_LATENCY=2), busy=0 in cycle 4.
- data_req=1, data_we=1, data_src=10: MemoryAdress=011, mem_wr=1 for exactly 2 cycles, data_ack pulse with mdr_load=0.
- exc_req, data_req and fetch_req all high in IDLE with exc_code=01: exc granted first with MemoryAdress=101, then data, then fetch; three acks in order, 4 cycles apart.
- exc_code=11: MemoryAdress=100, exc_ack as for a normal vector read.
- Reset asserted in WAIT of a store: next cycle mem_wr=0, busy=0, MemoryAdress=000, and no data_ack ever issued for that store.
- With MEM_SCHED_FAIRNESS_EN, FAIR_LIMIT=4, data_req and fetch_req held high:
  - Grants are 4 data then 1 fetch, repeating.
  - Without the macro: data only.
